// File: rtl/delay_line_pkg.sv
// Shared definitions for the delay_line block: FSM state encoding, the
// width derivation for the delay configuration input, and the saturation
// helper that clamps a requested delay to the buffer depth.
package delay_line_pkg;

  // Operating states of the delay line controller.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  // The delay input needs to represent 0..MAX_DELAY inclusive, hence one
  // extra bit over the address width.
  function automatic int delay_w_of(input int max_delay);
    return $clog2(max_delay) + 1;
  endfunction

  // Clamp a requested delay to the buffer depth. Oversized requests
  // saturate instead of wrapping, so a large delay never turns into a
  // short one by accident.
  function automatic int unsigned sat_delay(input int unsigned req,
                                            input int unsigned max_delay);
    return (req > max_delay) ? max_delay : req;
  endfunction

endpackage : delay_line_pkg

// File: rtl/delay_line_ram.sv
// Circular sample store for delay_line: one synchronous write port and one
// asynchronous read port. Because the read is combinational from the
// current array contents, a read of the entry being written in the same
// cycle returns the old data (read-before-write), which is what makes a
// delay equal to the full buffer depth work.
module delay_line_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // Storage is deliberately never cleared; the controller keeps stale
  // entries off the output by construction.
  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: one sample per enabled cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: combinational, sees pre-write contents this cycle.
  assign rdata = mem[raddr];

endmodule : delay_line_ram

// File: rtl/delay_line.sv
// Configurable-latency delay unit. A run pulse latches the requested delay
// (saturated to MAX_DELAY), resets the write pointer and fill counter, and
// then the block fills its circular buffer before streaming one delayed
// sample per cycle. Total latency from in0 to out0 is dq+1 cycles.
//
// Optional feature: define DELAY_LINE_VALID_EN to add the `valid` output,
// which marks the cycles where out0 carries a real sample.
module delay_line
  import delay_line_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_DELAY = 16,
  parameter int DELAY_W   = delay_w_of(MAX_DELAY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DELAY_W-1:0] delay,
  input  logic [DATA_W-1:0] in0,
  output logic [DATA_W-1:0] out0
`ifdef DELAY_LINE_VALID_EN
  ,
  output logic              valid
`endif
);

  localparam int AW = $clog2(MAX_DELAY);

  state_t             state_reg, state_next;
  logic [AW-1:0]      wptr_reg, wptr_next;
  logic [DELAY_W-1:0] cnt_reg, cnt_next;
  logic [DELAY_W-1:0] dq_reg, dq_next;
  logic [DATA_W-1:0]  out0_reg, out0_next;
`ifdef DELAY_LINE_VALID_EN
  logic               valid_reg, valid_next;
`endif

  logic               ram_we;
  logic [AW-1:0]      ram_raddr;
  logic [DATA_W-1:0]  ram_rdata;
  logic [DELAY_W-1:0] dq_req;

  // Requested delay clamped to the buffer depth.
  assign dq_req = DELAY_W'(sat_delay(32'(delay), 32'(MAX_DELAY)));

  // The sample written dq cycles ago sits dq entries behind the write
  // pointer. dq == MAX_DELAY reduces to the write address itself, served
  // by the RAM's read-before-write behaviour.
  assign ram_raddr = wptr_reg - dq_reg[AW-1:0];

  delay_line_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_DELAY),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wptr_reg),
    .wdata (in0),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Next-state, pointer, counter and output selection. A run pulse takes
  // priority in every state and forces the output to zero on its edge.
  always_comb begin
    state_next = state_reg;
    wptr_next  = wptr_reg;
    cnt_next   = cnt_reg;
    dq_next    = dq_reg;
    out0_next  = '0;
    ram_we     = 1'b0;
`ifdef DELAY_LINE_VALID_EN
    valid_next = 1'b0;
`endif

    if (run) begin
      dq_next    = dq_req;
      wptr_next  = '0;
      cnt_next   = '0;
      state_next = (dq_req == '0) ? STREAM : FILL;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = IDLE;
        end

        FILL: begin
          // Prime the buffer; output stays zero until dq samples are held.
          ram_we    = 1'b1;
          wptr_next = wptr_reg + AW'(1);
          cnt_next  = cnt_reg + DELAY_W'(1);
          if (cnt_reg == dq_reg - DELAY_W'(1)) begin
            state_next = STREAM;
          end
        end

        STREAM: begin
          // Steady state: write the new sample, emit the one dq cycles old,
          // or bypass the buffer entirely for a zero delay.
          ram_we    = 1'b1;
          wptr_next = wptr_reg + AW'(1);
          out0_next = (dq_reg == '0) ? in0 : ram_rdata;
`ifdef DELAY_LINE_VALID_EN
          valid_next = 1'b1;
`endif
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Controller and output registers, cleared by the active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      wptr_reg  <= '0;
      cnt_reg   <= '0;
      dq_reg    <= '0;
      out0_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wptr_reg  <= wptr_next;
      cnt_reg   <= cnt_next;
      dq_reg    <= dq_next;
      out0_reg  <= out0_next;
    end
  end

  assign out0 = out0_reg;

`ifdef DELAY_LINE_VALID_EN
  // Sample-present flag, aligned with out0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  assign valid = valid_reg;
`endif

endmodule : delay_line

// File: tb/tb_delay_line.sv
// Directed testbench for delay_line. Each run sequence issues a run pulse
// and then feeds an incrementing stream; the expected out0 for step j after
// the run (observed at cycle r+j+1) is base+(j-dq-1) once j > dq, else 0.
module tb_delay_line;

  localparam int DATA_W    = 32;
  localparam int MAX_DELAY = 16;
  localparam int DELAY_W   = 7;   // wide enough to request 40

  logic               clk;
  logic               rst;
  logic               run;
  logic [DELAY_W-1:0] delay;
  logic [DATA_W-1:0]  in0;
  logic [DATA_W-1:0]  out0;
`ifdef DELAY_LINE_VALID_EN
  logic               valid;
`endif

  int checks = 0;
  int errors = 0;

  delay_line #(
    .DATA_W    (DATA_W),
    .MAX_DELAY (MAX_DELAY),
    .DELAY_W   (DELAY_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .delay (delay),
    .in0   (in0),
    .out0  (out0)
`ifdef DELAY_LINE_VALID_EN
    ,
    .valid (valid)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    checks++;
    $display("%s out0=%h exp=%h", tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s out0=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_valid(input string tag, input logic exp);
`ifdef DELAY_LINE_VALID_EN
    checks++;
    assert (valid === exp) else begin
      errors++;
      $error("FAIL %s_valid valid=%b expected=%b", tag, valid, exp);
    end
`else
    if (exp === 1'bx) $display("%s", tag);
`endif
  endtask

  // Run pulse with requested delay d (effective dq), then n stream steps.
  task automatic run_seq(input string tag, input int d, input int dq,
                         input logic [DATA_W-1:0] base, input int n);
    logic [DATA_W-1:0] exp;
    run   = 1'b1;
    delay = DELAY_W'(d);
    in0   = 32'hDEAD_BEEF;
    tick();
    check({tag, "_run"}, out0, '0);
    check_valid({tag, "_run"}, 1'b0);
    run = 1'b0;
    for (int j = 1; j <= n; j++) begin
      in0 = base + 32'(j - 1);
      tick();
      exp = (j >= dq + 1) ? base + 32'(j - dq - 1) : '0;
      check($sformatf("%s_j%0d", tag, j), out0, exp);
      check_valid($sformatf("%s_j%0d", tag, j), (j >= dq + 1));
    end
  endtask

  initial begin
    // Reset held for two cycles with all-ones input.
    rst   = 1'b0;
    run   = 1'b0;
    delay = '0;
    in0   = 32'hFFFF_FFFF;
    tick();
    check("rst_c1", out0, '0);
    check_valid("rst_c1", 1'b0);
    tick();
    check("rst_c2", out0, '0);
    check_valid("rst_c2", 1'b0);

    // Released, no run: stays idle with zero output.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in0 = 32'hA5A5_0000 + 32'(i);
      tick();
      check($sformatf("idle_%0d", i), out0, '0);
      check_valid($sformatf("idle_%0d", i), 1'b0);
    end

    // Zero delay: plain one-cycle register.
    run_seq("d0", 0, 0, 32'h1, 8);
    // Delay 5.
    run_seq("d5", 5, 5, 32'h10, 12);
    // Oversized request saturates to 16.
    run_seq("d40", 40, 16, 32'h300, 22);
    // Full-depth delay, read-before-write on wrap.
    run_seq("d16", 16, 16, 32'h400, 22);
    // Streaming at 3, then restart mid-stream at 7.
    run_seq("d3", 3, 3, 32'h100, 8);
    run_seq("rs7", 7, 7, 32'h200, 14);

    // Reset in the middle of streaming.
    run_seq("d4a", 4, 4, 32'h500, 8);
    rst = 1'b0;
    in0 = 32'h5555_5555;
    tick();
    check("midrst", out0, '0);
    check_valid("midrst", 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in0 = 32'h7700_0000 + 32'(i);
      tick();
      check($sformatf("postrst_idle_%0d", i), out0, '0);
      check_valid($sformatf("postrst_idle_%0d", i), 1'b0);
    end
    run_seq("d4b", 4, 4, 32'h600, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_delay_line
